// File: rtl/axi_pkg.sv
// Shared AXI3 constants and FSM state types for the core's bus arbiter.
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int ID_INST = 0;
  localparam int ID_DATA = 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/axi_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the loser when a burst completes.
module axi_rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_owner,
  output logic [1:0] gnt
);
  logic ptr; // 1 favours req[1]

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     ptr <= 1'b1;
    else if (done) ptr <= ~done_owner;
  end

  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI3 master port between the inst-fetch read port and the data-cache read/write port.
module axi_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_INST = axi_pkg::ID_INST,
  parameter int ID_DATA = axi_pkg::ID_DATA
) (
  input  logic                clock,
  input  logic                reset,
  // inst read port
  input  logic                i_arvalid,
  output logic                i_arready,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  output logic                i_rvalid,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  // data port
  input  logic                d_arvalid,
  output logic                d_arready,
  input  logic [ADDR_W-1:0]   d_araddr,
  input  logic [7:0]          d_arlen,
  input  logic [2:0]          d_arsize,
  output logic                d_rvalid,
  input  logic                d_rready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  input  logic                d_awvalid,
  output logic                d_awready,
  input  logic [ADDR_W-1:0]   d_awaddr,
  input  logic [7:0]          d_awlen,
  input  logic [2:0]          d_awsize,
  input  logic                d_wvalid,
  output logic                d_wready,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_bvalid,
  input  logic                d_bready,
  // AXI3 master
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                err_rid
);
  import axi_pkg::*;

  rd_state_t         rd_state;
  wr_state_t         wr_state;
  logic              rd_owner; // 1 = data port
  logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
  logic [7:0]        ar_len_q, aw_len_q, w_cnt;
  logic [2:0]        ar_size_q, aw_size_q;
  logic [1:0]        rd_req, rd_gnt;
  logic [3:0]        owner_id;
  logic              r_data_ph, w_data_ph, d_rd_active, aw_take, r_done, w_beat;
  logic              unused;

  assign unused = ^{rresp, bresp, bid};

  // ---------------- read path ----------------
  assign d_rd_active = (rd_state != R_IDLE) && rd_owner;
  // A data read waits for the write FSM, including a write accepted this same cycle.
  assign rd_req = {d_arvalid && (wr_state == W_IDLE) && !d_awvalid, i_arvalid}
                  & {2{(rd_state == R_IDLE) && !reset}};

  axi_rr_arbiter2 u_rr (
    .clock      (clock),
    .reset      (reset),
    .req        (rd_req),
    .done       (r_done),
    .done_owner (rd_owner),
    .gnt        (rd_gnt)
  );

  assign i_arready = rd_gnt[0];
  assign d_arready = rd_gnt[1];
  assign owner_id  = rd_owner ? 4'(ID_DATA) : 4'(ID_INST);
  assign r_data_ph = (rd_state == R_DATA);

  assign i_rvalid = r_data_ph && !rd_owner && rvalid;
  assign d_rvalid = r_data_ph && rd_owner && rvalid;
  assign i_rdata  = rdata;
  assign d_rdata  = rdata;
  assign i_rlast  = rlast;
  assign d_rlast  = rlast;
  assign rready   = r_data_ph && (rd_owner ? d_rready : i_rready);
  assign r_done   = r_data_ph && rvalid && rready && rlast;

  assign arvalid = (rd_state == R_ADDR);
  assign arid    = owner_id;
  assign araddr  = ar_addr_q;
  assign arlen   = ar_len_q;
  assign arsize  = ar_size_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      rd_owner  <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (|rd_gnt) begin
          rd_owner  <= rd_gnt[1];
          ar_addr_q <= rd_gnt[1] ? d_araddr : i_araddr;
          ar_len_q  <= rd_gnt[1] ? d_arlen  : i_arlen;
          ar_size_q <= rd_gnt[1] ? d_arsize : i_arsize;
          rd_state  <= R_ADDR;
        end
        R_ADDR:  if (arready) rd_state <= R_DATA;
        R_DATA:  if (r_done)  rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   err_rid <= 1'b0;
    else if (r_data_ph && rvalid && rid != owner_id) err_rid <= 1'b1;
  end

  // ---------------- write path ----------------
  assign d_awready = !reset && (wr_state == W_IDLE) && !d_rd_active;
  assign aw_take   = d_awready && d_awvalid;
  assign w_data_ph = (wr_state == W_DATA);

  assign awvalid = (wr_state == W_ADDR);
  assign awid    = 4'(ID_DATA);
  assign awaddr  = aw_addr_q;
  assign awlen   = aw_len_q;
  assign awsize  = aw_size_q;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // The requester has no wlast, so the last beat is counted here.
  assign wvalid   = w_data_ph && d_wvalid;
  assign d_wready = w_data_ph && wready;
  assign wlast    = w_data_ph && (w_cnt == aw_len_q);
  assign wid      = 4'(ID_DATA);
  assign wdata    = d_wdata;
  assign wstrb    = d_wstrb;
  assign w_beat   = wvalid && wready;

  assign bready   = (wr_state == W_RESP) && d_bready;
  assign d_bvalid = (wr_state == W_RESP) && bvalid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state  <= W_IDLE;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      w_cnt     <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (aw_take) begin
          aw_addr_q <= d_awaddr;
          aw_len_q  <= d_awlen;
          aw_size_q <= d_awsize;
          w_cnt     <= '0;
          wr_state  <= W_ADDR;
        end
        W_ADDR: if (awready) wr_state <= W_DATA;
        W_DATA: if (w_beat) begin
          w_cnt <= w_cnt + 8'd1;
          if (wlast) wr_state <= W_RESP;
        end
        W_RESP:  if (bvalid && bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench: stimulus queues expected transfers/status, a negedge monitor scores them.
module tb_axi_bus_arbiter;
  logic        clock, reset;
  logic        i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic        d_arvalid, d_arready, d_rvalid, d_rready, d_rlast;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic [3:0]  d_wstrb;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, err_rid;

  axi_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .d_awvalid(d_awvalid), .d_awready(d_awready), .d_awaddr(d_awaddr), .d_awlen(d_awlen),
    .d_awsize(d_awsize), .d_wvalid(d_wvalid), .d_wready(d_wready), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .err_rid(err_rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int S_ARV = 0, S_RRDY = 1, S_IRV = 2, S_DRV = 3, S_IARR = 4, S_DARR = 5, S_AWR = 6;
  localparam int S_AWV = 7, S_WV = 8, S_WL = 9, S_BRDY = 10, S_DBV = 11, S_ERR = 12;
  logic [12:0] st;
  assign st = {err_rid, d_bvalid, bready, wlast, wvalid, awvalid, d_awready, d_arready,
               i_arready, d_rvalid, i_rvalid, rready, arvalid};

  typedef struct { string tag; int idx; logic val; } st_exp_t;
  st_exp_t     st_q[$];
  logic [63:0] ar_q[$], aw_q[$], ib_q[$], db_q[$], w_q[$];
  int          b_q[$];
  int          errors = 0, checks = 0;
  logic        done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  task automatic exp1(string tag, int idx, logic v); st_q.push_back('{tag, idx, v}); endtask
  task automatic push_ar(logic [3:0] id, logic [31:0] a, logic [7:0] l);
    ar_q.push_back({6'd0, id, a, l, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0});
  endtask
  task automatic push_aw(logic [31:0] a, logic [7:0] l);
    aw_q.push_back({6'd0, 4'd1, a, l, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0});
  endtask
  task automatic push_ib(logic [31:0] d, logic l); ib_q.push_back({31'd0, d, l}); endtask
  task automatic push_db(logic [31:0] d, logic l); db_q.push_back({31'd0, d, l}); endtask
  task automatic push_w(logic [31:0] d, logic l); w_q.push_back({23'd0, 4'd1, d, 4'hF, l}); endtask
  task automatic tick(); @(posedge clock); #1; endtask

  // Bounded wait on a status bit; on expiry the missing event is scored as a failed check.
  task automatic wait_st(int idx, string tag);
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (st[idx]) return;
    end
    exp1({tag, "_timeout"}, idx, 1'b1);
  endtask

  always @(negedge clock) begin
    st_exp_t e;
    while (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk(e.tag, 64'(st[e.idx]), 64'(e.val));
    end
    if (!reset) begin
      if (arvalid && arready) begin
        chk("ar_expected", 64'(ar_q.size() > 0), 64'd1);
        if (ar_q.size() > 0)
          chk("ar_fields", {6'd0, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}, ar_q.pop_front());
      end
      if (awvalid && awready) begin
        chk("aw_expected", 64'(aw_q.size() > 0), 64'd1);
        if (aw_q.size() > 0)
          chk("aw_fields", {6'd0, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot}, aw_q.pop_front());
      end
      if (i_rvalid && i_rready) begin
        chk("ibeat_expected", 64'(ib_q.size() > 0), 64'd1);
        if (ib_q.size() > 0) chk("ibeat", {31'd0, i_rdata, i_rlast}, ib_q.pop_front());
      end
      if (d_rvalid && d_rready) begin
        chk("dbeat_expected", 64'(db_q.size() > 0), 64'd1);
        if (db_q.size() > 0) chk("dbeat", {31'd0, d_rdata, d_rlast}, db_q.pop_front());
      end
      if (wvalid && wready) begin
        chk("wbeat_expected", 64'(w_q.size() > 0), 64'd1);
        if (w_q.size() > 0) chk("wbeat", {23'd0, wid, wdata, wstrb, wlast}, w_q.pop_front());
      end
      if (bvalid && bready) begin
        chk("b_expected", 64'(b_q.size() > 0), 64'd1);
        if (b_q.size() > 0) begin
          void'(b_q.pop_front());
          chk("d_bvalid", 64'(d_bvalid), 64'd1);
        end
      end
    end
    if (done) begin
      chk("ar_left", 64'(ar_q.size()), 64'd0);
      chk("aw_left", 64'(aw_q.size()), 64'd0);
      chk("ib_left", 64'(ib_q.size()), 64'd0);
      chk("db_left", 64'(db_q.size()), 64'd0);
      chk("w_left",  64'(w_q.size()),  64'd0);
      chk("b_left",  64'(b_q.size()),  64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {i_arvalid, i_rready, d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready} = '0;
    {i_araddr, d_araddr, d_awaddr, d_wdata} = '0;
    {i_arlen, d_arlen, d_awlen} = '0;
    i_arsize = 3'd2; d_arsize = 3'd2; d_awsize = 3'd2; d_wstrb = 4'hF;
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    rid = '0; rdata = '0; rresp = '0; bid = '0; bresp = '0;

    // reset: requests and slave valids present, every handshake output held low
    i_arvalid = 1; d_arvalid = 1; d_awvalid = 1; rvalid = 1; bvalid = 1; i_rready = 1;
    tick;
    exp1("rst_arvalid", S_ARV, 0);  exp1("rst_rready", S_RRDY, 0);  exp1("rst_i_rvalid", S_IRV, 0);
    exp1("rst_d_rvalid", S_DRV, 0); exp1("rst_i_arready", S_IARR, 0); exp1("rst_d_arready", S_DARR, 0);
    exp1("rst_d_awready", S_AWR, 0); exp1("rst_awvalid", S_AWV, 0); exp1("rst_wvalid", S_WV, 0);
    exp1("rst_d_bvalid", S_DBV, 0); exp1("rst_bready", S_BRDY, 0); exp1("rst_err_rid", S_ERR, 0);
    tick;
    i_arvalid = 0; d_arvalid = 0; d_awvalid = 0; rvalid = 0; bvalid = 0;
    reset = 1'b0;
    tick;
    exp1("idle_d_awready", S_AWR, 1);
    tick;

    // T1: inst burst len 3, arready delayed 2 cycles
    push_ar(4'd0, 32'hBFC0_0000, 8'd3);
    for (int k = 0; k < 4; k++) push_ib(32'hA0 + 32'(k), k == 3);
    i_araddr = 32'hBFC0_0000; i_arlen = 8'd3; i_rready = 1; d_rready = 1; i_arvalid = 1;
    wait_st(S_IARR, "t1_grant"); tick; i_arvalid = 0;
    exp1("t1_arvalid", S_ARV, 1);
    tick; tick; arready = 1; tick; arready = 0;
    for (int k = 0; k < 4; k++) begin
      rid = 4'd0; rdata = 32'hA0 + 32'(k); rlast = (k == 3); rvalid = 1;
      exp1("t1_i_rvalid", S_IRV, 1); exp1("t1_d_rvalid", S_DRV, 0);
      tick;
    end
    rvalid = 0; rlast = 0;
    exp1("t1_idle_arvalid", S_ARV, 0);
    tick;

    // T2: both ports held for three bursts -> data, inst, data
    i_araddr = 32'h1000; i_arlen = 0; d_araddr = 32'h2000; d_arlen = 0;
    push_ar(4'd1, 32'h2000, 0); push_ar(4'd0, 32'h1000, 0); push_ar(4'd1, 32'h2000, 0);
    push_db(32'hD0, 1); push_ib(32'hC1, 1); push_db(32'hD2, 1);
    arready = 1; i_arvalid = 1; d_arvalid = 1;
    for (int k = 0; k < 3; k++) begin
      wait_st(S_RRDY, "t2_rdata"); tick;
      rid = (k == 1) ? 4'd0 : 4'd1;
      rdata = (k == 1) ? 32'hC1 : ((k == 0) ? 32'hD0 : 32'hD2);
      rlast = 1; rvalid = 1; tick;
      rvalid = 0; rlast = 0;
      if (k == 2) begin i_arvalid = 0; d_arvalid = 0; end
    end
    tick;

    // T3: write len 1, wready low for 3 cycles
    d_awaddr = 32'h3000; d_awlen = 8'd1;
    push_aw(32'h3000, 8'd1); push_w(32'h11, 0); push_w(32'h22, 1); b_q.push_back(1);
    awready = 1; wready = 0; d_wdata = 32'h11; d_awvalid = 1;
    wait_st(S_AWR, "t3_aw"); tick; d_awvalid = 0;
    exp1("t3_awvalid", S_AWV, 1); d_wvalid = 1;
    tick;
    repeat (3) begin exp1("t3_wlast_stall", S_WL, 0); exp1("t3_wvalid", S_WV, 1); tick; end
    wready = 1; exp1("t3_wlast_b1", S_WL, 0); tick;
    d_wdata = 32'h22; exp1("t3_wlast_b2", S_WL, 1); tick;
    d_wvalid = 0; wready = 0;
    exp1("t3_d_bvalid_wait", S_DBV, 0); tick;
    bvalid = 1; d_bready = 1; exp1("t3_d_bvalid", S_DBV, 1); tick;
    bvalid = 0;
    exp1("t3_idle_awready", S_AWR, 1); exp1("t3_idle_d_bvalid", S_DBV, 0);
    tick;

    // T4: data read held off by a write in progress; inst read still served
    d_awaddr = 32'h4000; d_awlen = 0;
    push_aw(32'h4000, 0); push_w(32'h44, 1); b_q.push_back(1);
    d_wdata = 32'h44; wready = 0; d_awvalid = 1;
    wait_st(S_AWR, "t4_aw"); tick; d_awvalid = 0; d_wvalid = 1;
    tick;
    i_araddr = 32'h6000; i_arlen = 0; d_araddr = 32'h5000; d_arlen = 0; i_arvalid = 1; d_arvalid = 1;
    push_ar(4'd0, 32'h6000, 0); push_ib(32'h66, 1);
    exp1("t4_d_arready_wdata", S_DARR, 0); exp1("t4_i_arready", S_IARR, 1);
    tick; i_arvalid = 0;
    exp1("t4_d_arready_raddr", S_DARR, 0); tick;
    rid = 4'd0; rdata = 32'h66; rlast = 1; rvalid = 1; tick; rvalid = 0; rlast = 0;
    exp1("t4_d_arready_ridle", S_DARR, 0);
    wready = 1; tick; wready = 0; d_wvalid = 0;
    exp1("t4_d_arready_wresp", S_DARR, 0);
    bvalid = 1; tick; bvalid = 0;
    push_ar(4'd1, 32'h5000, 0); push_db(32'h55, 1);
    exp1("t4_d_arready_free", S_DARR, 1);
    tick; d_arvalid = 0;
    tick;
    exp1("t4_awready_dread", S_AWR, 0);
    rid = 4'd1; rdata = 32'h55; rlast = 1; rvalid = 1; tick; rvalid = 0; rlast = 0;
    tick;

    // T6: wrong rid on an inst burst sets the sticky error
    i_araddr = 32'h7000; i_arlen = 0;
    push_ar(4'd0, 32'h7000, 0); push_ib(32'h77, 1);
    i_arvalid = 1; wait_st(S_IARR, "t6_grant"); tick; i_arvalid = 0; tick;
    rid = 4'd1; rdata = 32'h77; rlast = 1; rvalid = 1;
    exp1("t6_err_before", S_ERR, 0); tick;
    rvalid = 0; rlast = 0; rid = 4'd0;
    exp1("t6_err_set", S_ERR, 1);
    repeat (3) tick;
    exp1("t6_err_sticky", S_ERR, 1);
    tick;

    // T5: reset during beat 2 of 4, then a normal request
    i_araddr = 32'h8000; i_arlen = 8'd3;
    push_ar(4'd0, 32'h8000, 8'd3); push_ib(32'h80, 0);
    i_arvalid = 1; wait_st(S_IARR, "t5_grant"); tick; i_arvalid = 0; tick;
    rid = 4'd0; rdata = 32'h80; rlast = 0; rvalid = 1; tick;
    rdata = 32'h81; #1 reset = 1'b1;
    exp1("t5_arvalid", S_ARV, 0); exp1("t5_rready", S_RRDY, 0);
    exp1("t5_i_rvalid", S_IRV, 0); exp1("t5_err_clear", S_ERR, 0);
    tick; reset = 1'b0; rvalid = 0;
    i_araddr = 32'h9000; i_arlen = 0;
    push_ar(4'd0, 32'h9000, 0); push_ib(32'h99, 1);
    i_arvalid = 1; wait_st(S_IARR, "t5_regrant"); tick; i_arvalid = 0; tick;
    rid = 4'd0; rdata = 32'h99; rlast = 1; rvalid = 1; tick; rvalid = 0; rlast = 0;
    exp1("t5_after_err", S_ERR, 0); exp1("t5_after_arvalid", S_ARV, 0);
    tick;
    done = 1'b1;
  end
endmodule
